// File: rtl/one_to_eight_demux.sv
// one_to_eight_demux
// Registered 1-to-8 demultiplexer / serial deserializer. It is the receiving
// end of an 8-to-1 mux lane scheme and steers one serial bit into one of
// eight held output lanes.
//   - Addressed mode (auto = 0): a valid bit is written to lane `sel`.
//   - Auto mode (auto = 1): a valid bit is written to lane `ptr`, and then
//     `ptr` advances. When lane 7 is captured, the completed byte is latched
//     into `frame` and `frame_done` pulses for one cycle.
//
// Optional feature macro: DEMUX_PARITY_EN
//   When defined, adds a registered `parity` output. It holds the XOR of the
//   completed frame and updates on the same edge as `frame`.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in          serial data bit
//   in_valid    capture `in` on this edge
//   sel [2:0]   lane address (addressed mode only)
//   auto        1 = pointer mode, 0 = addressed mode
//   clear       synchronous clear of lanes, pointer and frame state
//   out [7:0]   held lane register, bit k = lane k
//   frame [7:0] last completed auto-mode frame
//   frame_done  one-cycle pulse when `frame` updates
//   ptr [2:0]   auto-mode lane pointer
//   busy        auto-mode frame partially captured
//   parity      XOR of `frame` (DEMUX_PARITY_EN only)
module one_to_eight_demux #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic       in_valid,
    input  logic [2:0] sel,
    input  logic       auto,
    input  logic       clear,
    output logic [7:0] out,
    output logic [7:0] frame,
    output logic       frame_done,
    output logic [2:0] ptr,
`ifdef DEMUX_PARITY_EN
    output logic       parity,
`endif
    output logic       busy
);

    logic [7:0] out_n;
    logic [7:0] frame_n;
    logic       done_n;
    logic [2:0] ptr_n;
    logic       busy_n;
`ifdef DEMUX_PARITY_EN
    logic       parity_n;
`endif

    always_comb begin
        out_n   = out;
        frame_n = frame;
        done_n  = 1'b0;
        ptr_n   = ptr;
`ifdef DEMUX_PARITY_EN
        parity_n = parity;
`endif
        if (clear) begin
            // A bit that is valid in the same cycle as clear is dropped.
            out_n   = RESET_VAL;
            frame_n = RESET_VAL;
            ptr_n   = '0;
`ifdef DEMUX_PARITY_EN
            parity_n = 1'b0;
`endif
        end else if (!auto) begin
            // Addressed mode keeps the pointer parked at lane 0. As a result,
            // a switch into auto mode always starts a fresh frame.
            ptr_n = '0;
            if (in_valid) begin
                out_n[sel] = in;
            end
        end else if (in_valid) begin
            out_n[ptr] = in;
            ptr_n      = ptr + 3'd1;
            if (ptr == 3'd7) begin
                // The register does not yet hold lane 7, so the completed
                // word is assembled from the incoming bit.
                frame_n = {in, out[6:0]};
                done_n  = 1'b1;
`ifdef DEMUX_PARITY_EN
                parity_n = ^{in, out[6:0]};
`endif
            end
        end
        busy_n = auto && (ptr_n != 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= RESET_VAL;
            frame      <= RESET_VAL;
            frame_done <= 1'b0;
            ptr        <= '0;
            busy       <= 1'b0;
`ifdef DEMUX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            out        <= out_n;
            frame      <= frame_n;
            frame_done <= done_n;
            ptr        <= ptr_n;
            busy       <= busy_n;
`ifdef DEMUX_PARITY_EN
            parity     <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_one_to_eight_demux.sv
// tb_one_to_eight_demux
// Directed bench for one_to_eight_demux. It first applies a table of
// per-cycle vectors (reset, addressed writes, one auto frame). It then runs
// hand-written sequences for gapped and back-to-back frames, a clear in the
// middle of a frame, and a mode switch in the middle of a frame.
module tb_one_to_eight_demux;

    logic       clk = 1'b0;
    logic       rst, in, in_valid, auto, clear;
    logic [2:0] sel;
    logic [7:0] out, frame;
    logic       frame_done, busy;
    logic [2:0] ptr;
`ifdef DEMUX_PARITY_EN
    logic       parity;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    one_to_eight_demux #(.RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .sel(sel),
        .auto(auto), .clear(clear), .out(out), .frame(frame),
        .frame_done(frame_done), .ptr(ptr),
`ifdef DEMUX_PARITY_EN
        .parity(parity),
`endif
        .busy(busy)
    );

    typedef struct {
        logic       rst, clr, aut, iv, din;
        logic [2:0] sel;
        logic [7:0] e_out, e_frame;
        logic       e_done;
        logic [2:0] e_ptr;
        logic       e_busy, e_par;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic a,
                        input logic v, input logic d, input logic [2:0] s);
        rst = r; clear = c; auto = a; in_valid = v; in = d; sel = s;
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) n_done++;
    endtask

    // Feed one auto-mode valid bit and check the done pulse and pointer.
    task automatic auto_bit(input logic d, input int unsigned idx,
                            input logic [7:0] e_frame, input logic e_par);
        step(0, 0, 1, 1, d, 3'd5);
        if (idx == 7) begin
            chk("frame_done_last", {7'd0, frame_done}, 8'd1);
            chk("frame_last", frame, e_frame);
`ifdef DEMUX_PARITY_EN
            chk("parity_last", {7'd0, parity}, {7'd0, e_par});
`else
            if (e_par === 1'bx) chk("parity_unused", 8'd0, 8'd1);
`endif
        end else begin
            chk("frame_done_mid", {7'd0, frame_done}, 8'd0);
        end
        chk("ptr_auto", {5'd0, ptr}, 8'((idx + 1) % 8));
        chk("busy_auto", {7'd0, busy}, {7'd0, idx != 7});
    endtask

    function automatic vec_t mk(input logic r, c, a, v, d, input logic [2:0] s,
                                input logic [7:0] eo, ef, input logic ed,
                                input logic [2:0] ep, input logic eb);
        vec_t x;
        x.rst = r; x.clr = c; x.aut = a; x.iv = v; x.din = d; x.sel = s;
        x.e_out = eo; x.e_frame = ef; x.e_done = ed; x.e_ptr = ep;
        x.e_busy = eb; x.e_par = 1'b0;
        return x;
    endfunction

    initial begin
        logic [7:0] fa, fb, fc;
        rst = 1'b1; clear = 1'b0; auto = 1'b0; in_valid = 1'b1; in = 1'b1; sel = '0;

        // rst clr aut iv in sel | out frame done ptr busy
        vecs.push_back(mk(1,0,0,1,1,3'd0, 8'h00,8'h00,0,3'd0,0));
        vecs.push_back(mk(1,0,1,1,1,3'd0, 8'h00,8'h00,0,3'd0,0));
        vecs.push_back(mk(0,0,0,1,1,3'd0, 8'h01,8'h00,0,3'd0,0));
        vecs.push_back(mk(0,0,0,1,1,3'd1, 8'h03,8'h00,0,3'd0,0));
        vecs.push_back(mk(0,0,0,1,1,3'd4, 8'h13,8'h00,0,3'd0,0));
        vecs.push_back(mk(0,0,0,1,1,3'd6, 8'h53,8'h00,0,3'd0,0));
        vecs.push_back(mk(0,0,0,1,0,3'd3, 8'h53,8'h00,0,3'd0,0));
        vecs.push_back(mk(0,0,0,0,1,3'd2, 8'h53,8'h00,0,3'd0,0));
        vecs.push_back(mk(0,1,1,1,1,3'd7, 8'h00,8'h00,0,3'd0,0));
        // auto frame 1,1,0,0,1,0,1,0 (lane 0 first); sel deliberately nonzero
        vecs.push_back(mk(0,0,1,1,1,3'd7, 8'h01,8'h00,0,3'd1,1));
        vecs.push_back(mk(0,0,1,1,1,3'd7, 8'h03,8'h00,0,3'd2,1));
        vecs.push_back(mk(0,0,1,1,0,3'd7, 8'h03,8'h00,0,3'd3,1));
        vecs.push_back(mk(0,0,1,1,0,3'd7, 8'h03,8'h00,0,3'd4,1));
        vecs.push_back(mk(0,0,1,1,1,3'd7, 8'h13,8'h00,0,3'd5,1));
        vecs.push_back(mk(0,0,1,1,0,3'd7, 8'h13,8'h00,0,3'd6,1));
        vecs.push_back(mk(0,0,1,1,1,3'd7, 8'h53,8'h00,0,3'd7,1));
        vecs.push_back(mk(0,0,1,1,0,3'd7, 8'h53,8'h53,1,3'd0,0));
        vecs.push_back(mk(0,0,1,0,1,3'd7, 8'h53,8'h53,0,3'd0,0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].aut, vecs[i].iv, vecs[i].din, vecs[i].sel);
            chk($sformatf("v%0d_out", i), out, vecs[i].e_out);
            chk($sformatf("v%0d_frame", i), frame, vecs[i].e_frame);
            chk($sformatf("v%0d_done", i), {7'd0, frame_done}, {7'd0, vecs[i].e_done});
            chk($sformatf("v%0d_ptr", i), {5'd0, ptr}, {5'd0, vecs[i].e_ptr});
            chk($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].e_busy});
`ifdef DEMUX_PARITY_EN
            chk($sformatf("v%0d_par", i), {7'd0, parity}, {7'd0, vecs[i].e_par});
`endif
        end

        // Gapped frame 0x53, then back-to-back frame 0xC2 with no bubble.
        n_done = 0;
        fa = 8'h53;
        fb = 8'hC2;
        for (int unsigned i = 0; i < 8; i++) begin
            auto_bit(fa[i], i, 8'h53, 1'b0);
            if (i != 7) begin
                step(0, 0, 1, 0, 1, 3'd0);
                chk("gap_done", {7'd0, frame_done}, 8'd0);
                chk("gap_ptr", {5'd0, ptr}, 8'(i + 1));
            end
        end
        for (int unsigned i = 0; i < 8; i++) auto_bit(fb[i], i, 8'hC2, 1'b1);
        chk("b2b_out", out, 8'hC2);
        step(0, 0, 1, 0, 0, 3'd0);
        chk("b2b_done_drop", {7'd0, frame_done}, 8'd0);
        chk("b2b_pulses", 8'(n_done), 8'd2);

        // Clear after three bits; the bit presented with clear is dropped.
        auto_bit(1'b1, 0, 8'h00, 1'b0);
        auto_bit(1'b0, 1, 8'h00, 1'b0);
        auto_bit(1'b1, 2, 8'h00, 1'b0);
        step(0, 1, 1, 1, 1, 3'd0);
        chk("clr_out", out, 8'h00);
        chk("clr_frame", frame, 8'h00);
        chk("clr_ptr", {5'd0, ptr}, 8'd0);
        chk("clr_busy", {7'd0, busy}, 8'd0);
        chk("clr_done", {7'd0, frame_done}, 8'd0);
        fc = 8'hA5;
        for (int unsigned i = 0; i < 8; i++) auto_bit(fc[i], i, 8'hA5, 1'b0);
        chk("clr_new_out", out, 8'hA5);

        // Leave auto mode after five bits, then restart at lane 0.
        for (int unsigned i = 0; i < 5; i++) auto_bit(1'b1, i, 8'h00, 1'b0);
        chk("sw_out5", out, 8'hBF);
        step(0, 0, 0, 0, 0, 3'd0);
        chk("sw_ptr", {5'd0, ptr}, 8'd0);
        chk("sw_busy", {7'd0, busy}, 8'd0);
        chk("sw_done", {7'd0, frame_done}, 8'd0);
        chk("sw_out_keep", out, 8'hBF);
        chk("sw_frame_keep", frame, 8'hA5);
        auto_bit(1'b0, 0, 8'h00, 1'b0);
        chk("sw_restart_out", out, 8'hBE);
        for (int unsigned i = 1; i < 8; i++) auto_bit(i == 7, i, 8'h80, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
